// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_pkg
// Description : Register map, CTRL/STATUS bit positions and FSM states for
//               the programmable timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PERIOD   = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_W        = 3;

    localparam int STATUS_PENDING = 0;
    localparam int STATUS_RUNNING = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Prescale counter; ticks whenever the count reaches or passes
//               the limit, then restarts from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              run,
    input  logic [DATA_W-1:0] limit,
    output logic              tick
);

    logic [DATA_W-1:0] r_count;

    // >= rather than == so a limit lowered below the count fires at once
    assign tick = run && (r_count >= limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || !run || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DATA_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl
// Description : CPU-programmable timer: CTRL/PERIOD/PRESCALE/STATUS registers,
//               run/idle sequencing, one-cycle expiry pulse and level irq.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              expire,
    output logic              irq
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [DATA_W-1:0]  r_period;
    logic [DATA_W-1:0]  r_prescale;
    logic [DATA_W-1:0]  r_count;
    logic               r_pending;
    logic               r_expire;

    logic               w_ctrl_wr;
    logic               w_status_clr;
    logic               w_tick;
    logic               w_expiry;
    logic               w_running;

    assign w_ctrl_wr    = wr_en && (addr == ADDR_CTRL);
    assign w_status_clr = wr_en && (addr == ADDR_STATUS) && wdata[STATUS_PENDING];
    assign w_running    = (r_state == ST_RUN);

    tick_divider #(
        .DATA_W (DATA_W)
    ) u_tick_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_ctrl_wr),
        .run    (w_running),
        .limit  (r_prescale),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A CTRL write (stop or restart) always pre-empts an expiry on the same edge
    always_comb begin
        w_next_state = r_state;
        w_expiry     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl_wr && wdata[CTRL_EN]) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ctrl_wr) begin
                    if (!wdata[CTRL_EN]) begin
                        w_next_state = ST_IDLE;
                    end
                end else if (w_tick && (r_count >= r_period)) begin
                    w_expiry = 1'b1;
                    if (!r_ctrl[CTRL_PERIODIC]) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_period   <= '0;
            r_prescale <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= wdata[CTRL_W-1:0];
            end else if (w_expiry && !r_ctrl[CTRL_PERIODIC]) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end
            if (wr_en && (addr == ADDR_PERIOD)) begin
                r_period <= wdata;
            end
            if (wr_en && (addr == ADDR_PRESCALE)) begin
                r_prescale <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_pending <= 1'b0;
            r_expire  <= 1'b0;
        end else begin
            if (w_ctrl_wr || !w_running || w_expiry) begin
                r_count <= '0;
            end else if (w_tick) begin
                r_count <= r_count + DATA_W'(1);
            end
            // Set has priority over the W1C clear
            if (w_expiry) begin
                r_pending <= 1'b1;
            end else if (w_status_clr) begin
                r_pending <= 1'b0;
            end
            r_expire <= w_expiry;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:     rdata[CTRL_W-1:0] = r_ctrl;
            ADDR_PERIOD:   rdata             = r_period;
            ADDR_PRESCALE: rdata             = r_prescale;
            default: begin
                rdata[STATUS_PENDING] = r_pending;
                rdata[STATUS_RUNNING] = w_running;
            end
        endcase
    end

    assign expire = r_expire;
    assign irq    = r_pending && r_ctrl[CTRL_IRQ_EN];

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_timer_ctrl
// Description : Self-checking bench for timer_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;

    localparam int DW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    addr  = 2'd0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          expire;
    logic          irq;

    timer_ctrl #(.DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .expire (expire),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [2:0] m_ctrl;
    int         m_period, m_prescale, m_pc, m_mc;
    bit         m_pending, m_run, m_expire;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 3'd0; m_period = 0; m_prescale = 0;
        m_pc = 0; m_mc = 0; m_pending = 0; m_run = 0; m_expire = 0;
    endtask

    task automatic model_step(input bit we, input logic [1:0] a, input logic [DW-1:0] d);
        bit ctrl_wr, tick, ex;
        ctrl_wr = we && (a == 2'd0);
        tick    = m_run && (m_pc >= m_prescale);
        ex      = tick && (m_mc >= m_period) && !ctrl_wr;
        m_expire = ex;
        if (ex) m_pending = 1;
        else if (we && a == 2'd3 && d[0]) m_pending = 0;
        if (ctrl_wr) begin
            m_pc = 0; m_mc = 0; m_ctrl = d[2:0]; m_run = d[0];
        end else if (!m_run) begin
            m_pc = 0; m_mc = 0;
        end else begin
            m_pc = tick ? 0 : m_pc + 1;
            if (ex) begin
                m_mc = 0;
                if (!m_ctrl[1]) begin
                    m_run = 0; m_ctrl[0] = 1'b0;
                end
            end else if (tick) begin
                m_mc = m_mc + 1;
            end
        end
        if (we && a == 2'd1) m_period   = int'(d);
        if (we && a == 2'd2) m_prescale = int'(d);
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [1:0] a);
        logic [DW-1:0] v;
        v = '0;
        case (a)
            2'd0: v[2:0] = m_ctrl;
            2'd1: v = m_period[DW-1:0];
            2'd2: v = m_prescale[DW-1:0];
            default: begin
                v[0] = m_pending;
                v[1] = m_run;
            end
        endcase
        return v;
    endfunction

    // One clock: drive at negedge, step model at the edge, compare 1 ns later
    task automatic cyc(input bit we, input logic [1:0] a, input logic [DW-1:0] d);
        wr_en = we; addr = a; wdata = d;
        @(posedge clk);
        model_step(we, a, d);
        #1;
        wr_en = 1'b0;
        chk("expire", expire, m_expire);
        chk("irq", irq, m_pending && m_ctrl[2]);
        chk("rdata", rdata, exp_rd(a));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'($urandom_range(0, 3)), DW'($urandom));
    endtask

    task automatic wait_expire(input int max, output int n);
        n = 0;
        do begin
            cyc(1'b0, 2'd3, '0);
            n++;
        end while (!expire && n < max);
        if (!expire) chk("wait_expire timeout", expire, 1);
    endtask

    int n, cnt;
    logic [DW-1:0] d;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset values
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk("reset rdata", rdata, 0);
        end
        chk("reset expire", expire, 0);
        chk("reset irq", irq, 0);
        @(negedge clk);
        idle(4);

        // 2: periodic, PERIOD=3, PRESCALE=0, irq enabled
        cyc(1, 2'd2, 16'd0);
        cyc(1, 2'd1, 16'd3);
        cyc(1, 2'd0, 16'd7);
        wait_expire(20, n);
        chk("first expire latency", n, 4);
        chk("irq after first expire", irq, 1);
        wait_expire(20, n);
        chk("periodic gap", n, 4);
        cyc(1, 2'd3, 16'd1);
        chk("irq after w1c", irq, 0);
        wait_expire(20, n);
        chk("gap after w1c", n, 3);
        chk("irq relatch", irq, 1);

        // 5: W1C on the same edge as an expiry
        idle(3);
        cyc(1, 2'd3, 16'd1);
        chk("w1c+expire expire", expire, 1);
        chk("w1c+expire pending", rdata[0], 1);
        chk("w1c+expire irq", irq, 1);
        cyc(1, 2'd0, 16'd0);
        cyc(0, 2'd3, 16'd0);
        chk("stopped running bit", rdata[1], 0);

        // 3: one-shot, PRESCALE=2, PERIOD=1
        cyc(1, 2'd2, 16'd2);
        cyc(1, 2'd1, 16'd1);
        cyc(1, 2'd3, 16'd1);
        cyc(1, 2'd0, 16'd1);
        wait_expire(30, n);
        chk("oneshot latency", n, 6);
        cyc(0, 2'd3, 16'd0);
        chk("oneshot status", rdata, 1);
        cyc(0, 2'd0, 16'd0);
        chk("oneshot ctrl", rdata, 0);
        chk("oneshot irq masked", irq, 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(0, 2'($urandom_range(0, 3)), '0);
            if (expire) cnt++;
        end
        chk("oneshot no more pulses", cnt, 0);

        // 4: shrink PERIOD below the running count
        cyc(1, 2'd2, 16'd0);
        cyc(1, 2'd1, 16'd100);
        cyc(1, 2'd0, 16'd3);
        idle(25);
        cyc(1, 2'd1, 16'd5);
        wait_expire(20, n);
        chk("shrunk period immediate", n, 1);
        wait_expire(20, n);
        chk("shrunk period gap", n, 6);

        // 6: asynchronous reset mid-run with expire every cycle
        cyc(1, 2'd1, 16'd0);
        cyc(1, 2'd0, 16'd7);
        idle(2);
        chk("pre-reset expire", expire, 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset expire", expire, 0);
        chk("async reset irq", irq, 0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #0.2;
            chk("async reset rdata", rdata, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 2'($urandom_range(0, 3)), '0);
            if (expire) cnt++;
        end
        chk("no expire after reset", cnt, 0);
        cyc(1, 2'd0, 16'd7);
        wait_expire(10, n);
        chk("re-enable latency", n, 1);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            d = DW'($urandom);
            if (r < 4) begin
                if (r < 3) d[0] = 1'b1;
                cyc(1, 2'd0, d);
            end else if (r < 8) begin
                cyc(1, 2'd1, (r == 7) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 9)));
            end else if (r < 11) begin
                cyc(1, 2'd2, DW'($urandom_range(0, 3)));
            end else if (r < 15) begin
                cyc(1, 2'd3, d);
            end else begin
                cyc(0, 2'($urandom_range(0, 3)), d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
